spi_target: RTL
===============

Name: spi_target

Overview:
- SPI receiver (target side) for the SoC's master-only SPI peripheral.
- Samples spi_cs, spi_clk and spi_mosi, assembles bytes MSB-first and buffers them in a FIFO.
- Exposes the FIFO to the CPU as a memory-mapped slave on the select/wstrb/addr/ready bus, with a level interrupt for the CPU irq vector.
- Intended placement: 80000500-8000050f.

Parameters:
- FIFO_DEPTH, 8, received-byte FIFO entries; power of 2, range 2..64.
- SYNC_STAGES, 2, synchroniser flops on spi_cs/spi_clk/spi_mosi; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- select  in  1  slave select from address decoder; held while the CPU transaction is pending.
- wstrb  in  4  byte write strobes; all 0 means a read.
- addr  in  4  byte address within block; addr[3:2] selects the register.
- data_i  in  32  write data.
- ready  out  1  transaction-complete pulse.
- data_o  out  32  read data, valid while ready=1.
- irq  out  1  level interrupt.
- spi_cs  in  1  chip select, active low, asynchronous to clk.
- spi_clk  in  1  SPI clock, mode 0, asynchronous.
- spi_mosi  in  1  serial data in.

Behaviour:
- Reset values: ready=0, data_o=0, irq=0, FIFO empty, bit counter 0, CTRL=0, all sticky flags 0.
- SPI input conditioning:
  - spi_cs, spi_clk and spi_mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised spi_clk.
  - Requires f_spi_clk <= f_clk/4.
- Receive state machine, states IDLE, SHIFT, COMMIT:
  - IDLE: when CTRL.EN=1 and synced cs=0, go to SHIFT with bitcnt=0.
  - SHIFT: on each synced spi_clk rising edge, shift = {shift[6:0], mosi} and bitcnt += 1. When bitcnt wraps from 7 to 0, go to COMMIT.
  - COMMIT (one cycle): push the byte if the FIFO is not full, else drop it and set STAT.OVR. Then return to SHIFT if cs=0, else IDLE.
  - cs rising edge in SHIFT with bitcnt != 0: discard the partial byte, set STAT.SHORT, go to IDLE.
  - cs rising edge with bitcnt == 0: go to IDLE, no flag.
  - CTRL.EN written to 0 mid-frame: same as a cs rise, except no SHORT flag.
  - Falling spi_clk edges are ignored.
- Bus handshake:
  - ready <= select & ~ready, so there is exactly one cycle of latency. The pulse repeats only if select is held, which the decoder does not do after ready.
  - data_o is registered alongside ready.
  - Side effects (pop, write, clear) happen exactly once, in the cycle ready=1.
  - Reads with select=0 return 0.
- Register map:
  - 0x0 DATA (read-only):
    - [7:0]=FIFO head, [8]=1 if a byte was returned; pops the head.
    - Empty read returns 0x000 with no pointer change.
  - 0x4 STATUS:
    - [0] not_empty, [1] full, [2] OVR (sticky), [3] SHORT (sticky), [4] synced cs active, [14:8] fill count.
    - Write: each 1 written to [2] or [3] clears that flag (W1C).
  - 0x8 CTRL, RW:
    - [0] EN, [1] IRQ_EN, [2] FLUSH.
    - FLUSH is self-clearing: empties the FIFO in the ready cycle, and reads back 0.
    - Writes honour wstrb[0] only.
  - 0xC: TXDATA when SPI_TARGET_MISO_EN is defined, else reads 0 and writes are ignored.
- FIFO boundaries:
  - Pop and push in the same cycle while full: both happen, no OVR, count unchanged.
  - Same cycle while empty: the pop returns invalid (bit 8=0) and the push is accepted; count becomes 1.
  - Pointers are log2(FIFO_DEPTH) bits with an extra wrap bit; full = pointers equal except the wrap bit.
  - OVR set and W1C clear in the same cycle: set wins.
- irq = IRQ_EN & (not_empty | OVR), registered with one cycle of latency.
- Reset mid-frame: everything returns to reset values immediately. Bits already clocked in are lost, and the receiver stays in IDLE until EN=1 and a fresh cs fall.

Optional Feature:
- Macro: SPI_TARGET_MISO_EN.
- Defined:
  - Adds port spi_miso  out  1, reset 0.
  - Adds register 0xC TXDATA[7:0] (RW).
  - At each byte start in SHIFT, TXDATA is loaded into a TX shifter. The MSB drives spi_miso, and the shifter advances on each synced spi_clk falling edge.
  - When cs is high, spi_miso=0.
  - If TXDATA is not rewritten, the same byte repeats.
- Undefined: no spi_miso port, no TX logic, 0xC reads 0.

Test Plan:
- Reset, EN=1, master sends 0xA5 then 0x3C in one cs frame -> STATUS count=2; DATA reads 0x1A5 then 0x13C; third read 0x000.
- IRQ_EN=1, send one byte 0x81 -> irq=1 two to five clk after the COMMIT cycle; read DATA -> irq=0 one cycle after ready.
- FIFO_DEPTH=8, send 9 bytes 0x00..0x08 without reads -> full=1, OVR=1; reads return 0x00..0x07; write STATUS 0x4 -> OVR=0, irq drops.
- cs raised after 5 bits -> SHORT=1, count unchanged; next full frame byte 0x55 is received correctly as 0x155.
- Reset asserted after 3 bits, released, EN=1, new frame 0xF0 -> only 0xF0 in FIFO, count=1.
- SPI_TARGET_MISO_EN defined, TXDATA=0xC3, master clocks one byte -> spi_miso bit sequence 1,1,0,0,0,0,1,1 sampled on rising edges.

Source files
------------

// File: rtl/spi_target.sv
`timescale 1ns/1ps
// spi_target: mode-0 SPI receiver -> byte FIFO -> CPU bus slave (1-cycle ready pulse, no backpressure; overflow drops bytes).
// Define SPI_TARGET_MISO_EN to add the TXDATA register and the spi_miso transmit shifter.
module spi_target #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        irq,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_mosi
`ifdef SPI_TARGET_MISO_EN
  ,
  output logic        spi_miso
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SPI_TARGET_MISO_EN
  localparam int WD = 8;
`else
  localparam int WD = 4;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, nstate;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] fill_sr;
  logic cs_s, sclk_s, mosi_s, sclk_prev, settled, armed, sclk_rise;

  logic       en, irq_en, ovr, short;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       shift_en, push_req, short_set, cnt_clr;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        empty, full, push_ok, pop, ovr_set, flush;
  logic [7:0]  head;

  logic          req, wr_pend, wr_b0, pop_pend, wr_ev, ctrl_wr, stat_wr, tx_wr;
  logic [1:0]    wr_addr;
  logic [WD-1:0] wr_dat;
  logic [31:0]   rd_val;
  logic [6:0]    cnt7;
  logic [7:0]    txdata;
  logic          unused_bits;

  assign unused_bits = ^{addr[1:0], data_i[31:WD]};

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign settled   = fill_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // cs resets to its inactive level; fill_sr marks when the chains hold real pin samples
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      fill_sr   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      fill_sr   <= {fill_sr[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
    end
  end

  // A frame may only start after cs has been seen high while enabled, so a frame
  // already in progress at reset or at EN=1 is ignored until a fresh cs fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else begin
      armed <= (cs_s & settled) | (armed & en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (en && !cs_s && armed) nstate = SHIFT;
      end
      SHIFT: begin
        if (!en || cs_s) begin
          nstate = IDLE;
        end else if (sclk_rise && bitcnt == 3'd7) begin
          nstate = COMMIT;
        end
      end
      COMMIT: begin
        nstate = (en && !cs_s) ? SHIFT : IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = 1'b0;
    push_req  = 1'b0;
    short_set = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE:    cnt_clr = 1'b1;
      SHIFT: begin
        shift_en  = en & ~cs_s & sclk_rise;
        short_set = en & cs_s & (bitcnt != 3'd0);
      end
      COMMIT:  push_req = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt <= 3'd0;
      shreg  <= 8'd0;
    end else if (cnt_clr) begin
      bitcnt <= 3'd0;
    end else if (shift_en) begin
      bitcnt <= bitcnt + 3'd1;
      shreg  <= {shreg[6:0], mosi_s};
    end
  end

  assign count   = wr_ptr - rd_ptr;
  assign cnt7    = 7'(count);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign pop     = ready & pop_pend;
  assign push_ok = push_req & (~full | pop) & ~flush;
  assign ovr_set = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // The request is captured at issue so side effects do not depend on select
  // still being held during the ready cycle.
  assign req     = select & ~ready;
  assign wr_ev   = ready & wr_pend & wr_b0;
  assign ctrl_wr = wr_ev & (wr_addr == 2'd2);
  assign stat_wr = wr_ev & (wr_addr == 2'd1);
  assign tx_wr   = wr_ev & (wr_addr == 2'd3);
  assign flush   = ctrl_wr & wr_dat[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend  <= 1'b0;
      wr_b0    <= 1'b0;
      wr_addr  <= 2'd0;
      wr_dat   <= '0;
      pop_pend <= 1'b0;
    end else begin
      wr_pend  <= req & (|wstrb);
      wr_b0    <= wstrb[0];
      wr_addr  <= addr[3:2];
      wr_dat   <= data_i[WD-1:0];
      pop_pend <= req & (wstrb == 4'd0) & (addr[3:2] == 2'd0) & ~empty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
      ovr    <= 1'b0;
      short  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en     <= wr_dat[0];
        irq_en <= wr_dat[1];
      end
      ovr   <= ovr_set | (ovr & ~(stat_wr & wr_dat[2]));
      short <= short_set | (short & ~(stat_wr & wr_dat[3]));
    end
  end

  always_comb begin
    rd_val = 32'd0;
    case (addr[3:2])
      2'd0:    rd_val = empty ? 32'd0 : {23'd0, 1'b1, head};
      2'd1:    rd_val = {17'd0, cnt7, 3'd0, ~cs_s, short, ovr, full, ~empty};
      2'd2:    rd_val = {29'd0, 1'b0, irq_en, en};
      default: rd_val = {24'd0, txdata};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready  <= 1'b0;
      data_o <= 32'd0;
      irq    <= 1'b0;
    end else begin
      ready  <= req;
      data_o <= (req && wstrb == 4'd0) ? rd_val : 32'd0;
      irq    <= irq_en & (~empty | ovr);
    end
  end

`ifdef SPI_TARGET_MISO_EN
  logic [7:0] tx_shift, tx_nxt;
  logic       sclk_fall, tx_load, tx_adv;

  assign sclk_fall = ~sclk_s & sclk_prev;
  assign tx_load   = (state != SHIFT) && (nstate == SHIFT);
  // the fall after the last rise of a byte lands with bitcnt already wrapped, so it is skipped
  assign tx_adv    = (state == SHIFT) && sclk_fall && (bitcnt != 3'd0);

  always_comb begin
    tx_nxt = tx_shift;
    if (tx_load) begin
      tx_nxt = txdata;
    end else if (tx_adv) begin
      tx_nxt = {tx_shift[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txdata   <= 8'd0;
      tx_shift <= 8'd0;
      spi_miso <= 1'b0;
    end else begin
      if (tx_wr) txdata <= wr_dat;
      tx_shift <= tx_nxt;
      spi_miso <= (nstate != IDLE && !cs_s) ? tx_nxt[7] : 1'b0;
    end
  end
`else
  logic unused_tx;
  assign txdata    = 8'd0;
  assign unused_tx = tx_wr;
`endif

endmodule
